// File: rtl/usb_pkg.sv
// usb_pkg: shared USB PID constants, packet field offsets and rx sequencer state type
package usb_pkg;

    localparam logic [3:0] ACK   = 4'b0100;
    localparam logic [3:0] NAK   = 4'b0101;
    localparam logic [3:0] DATA0 = 4'b1100;

    localparam int PKT_W = 99;

    // handshake packet: PID then its complement
    localparam int HS_PID_HI  = 7;
    localparam int HS_PID_LO  = 4;
    localparam int HS_NPID_HI = 3;
    localparam int HS_NPID_LO = 0;

    // data packet: PID, 64-bit payload, CRC16
    localparam int DT_PID_HI = 87;
    localparam int DT_PID_LO = 84;
    localparam int DT_PL_HI  = 79;
    localparam int DT_PL_LO  = 16;
    localparam int DT_CRC_HI = 15;
    localparam int DT_CRC_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RESP,
        S_RETRY,
        S_DONE_OK,
        S_DONE_ERR
    } rx_state_t;

endpackage

// File: rtl/usb_rx_ctrl_if.sv
// usb_rx_ctrl_if: decoder/encoder-side signals of the host rx sequencer
//   slave  (sequencer): receives start/isIn/pkt/pktOutAvail/valid,
//                       drives decEn/resend/sendAck/txDone/success/dataOut/retries
//   master (driver)   : the opposite directions
interface usb_rx_ctrl_if;
    import usb_pkg::*;

    logic             start;
    logic             isIn;
    logic [PKT_W-1:0] pkt;
    logic             pktOutAvail;
    logic             valid;
    logic             decEn;
    logic             resend;
    logic             sendAck;
    logic             txDone;
    logic             success;
    logic [63:0]      dataOut;
    logic [3:0]       retries;

    modport slave (
        input  start, isIn, pkt, pktOutAvail, valid,
        output decEn, resend, sendAck, txDone, success, dataOut, retries
    );

    modport master (
        output start, isIn, pkt, pktOutAvail, valid,
        input  decEn, resend, sendAck, txDone, success, dataOut, retries
    );

endinterface

// File: rtl/usb_rx_ctrl_timer.sv
// rx_timer: response-window counter with clear/enable and terminal count at TIMEOUT-1
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count enable
//   tc       : high while the count equals TIMEOUT-1
module rx_timer #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

    assign tc = cnt == CW'(TIMEOUT - 1);

endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: host transaction sequencer - response window, classification, timeout, retry
//   clk, rst : clock, asynchronous active-high reset
//   bus      : usb_rx_ctrl_if.slave (start/isIn/pkt/pktOutAvail/valid in;
//              decEn/resend/sendAck/txDone/success/dataOut/retries out)
module usb_rx_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 8,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    usb_rx_ctrl_if.slave  bus
);

    localparam logic [3:0] MR = 4'(MAX_RETRY);

    rx_state_t   state, state_nx;
    logic        in_q;
    logic [3:0]  retries_q;
    logic [63:0] data_q;
    logic        tc;
    logic        accept;
    logic        unused_bits;

    // IN expects an intact DATA0, OUT expects an intact ACK; everything else is a retry
    assign accept = bus.valid && (in_q ? bus.pkt[DT_PID_HI:DT_PID_LO] == DATA0
                                       : bus.pkt[HS_PID_HI:HS_PID_LO] == ACK);

    assign unused_bits = ^{bus.pkt[PKT_W-1:DT_PID_HI+1], bus.pkt[DT_PID_LO-1:DT_PL_HI+1],
                           bus.pkt[DT_CRC_HI:HS_PID_HI+1], bus.pkt[HS_NPID_HI:HS_NPID_LO]};

    // timer is held clear outside the window, so every entry starts from 0
    rx_timer #(.TIMEOUT(TIMEOUT), .CW(CW)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (state != S_WAIT_RESP),
        .en  (state == S_WAIT_RESP),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      state_nx = bus.start ? S_WAIT_RESP : S_IDLE;
            S_WAIT_RESP: state_nx = bus.pktOutAvail ? (accept ? S_DONE_OK : S_RETRY)
                                                    : (tc ? S_RETRY : S_WAIT_RESP);
            S_RETRY:     state_nx = (retries_q == MR) ? S_DONE_ERR : S_WAIT_RESP;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q      <= 1'b0;
            retries_q <= '0;
            data_q    <= '0;
        end else begin
            if (state == S_IDLE && bus.start) begin
                in_q      <= bus.isIn;
                retries_q <= '0;
            end
            if (state == S_RETRY && retries_q != MR)
                retries_q <= retries_q + 4'd1;
            if (state == S_WAIT_RESP && bus.pktOutAvail && accept && in_q)
                data_q <= bus.pkt[DT_PL_HI:DT_PL_LO];
        end
    end

    always_comb begin
        bus.decEn   = state == S_WAIT_RESP;
        bus.resend  = state == S_RETRY && retries_q != MR;
        bus.sendAck = state == S_DONE_OK && in_q;
        bus.txDone  = state == S_DONE_OK || state == S_DONE_ERR;
        bus.success = state == S_DONE_OK;
        bus.dataOut = data_q;
        bus.retries = retries_q;
    end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl: two sequencer instances (long and short window) against a behavioural model
module tb_usb_rx_ctrl;

    localparam int TA = 16, RA = 3;
    localparam int TB = 4,  RB = 2;
    localparam logic [3:0] P_ACK = 4'b0100, P_NAK = 4'b0101, P_D0 = 4'b1100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_rx_ctrl_if ia ();
    usb_rx_ctrl_if ib ();

    assign ib.start       = ia.start;
    assign ib.isIn        = ia.isIn;
    assign ib.pkt         = ia.pkt;
    assign ib.pktOutAvail = ia.pktOutAvail;
    assign ib.valid       = ia.valid;

    usb_rx_ctrl #(.TIMEOUT(TA), .MAX_RETRY(RA), .CW(5)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    usb_rx_ctrl #(.TIMEOUT(TB), .MAX_RETRY(RB), .CW(3)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    // window open / age in window / awaiting retry decision / finished ok or err
    typedef struct packed {
        bit          win;
        int          age;
        bit          retry;
        bit          ok;
        bit          err;
        bit          dir;
        int          rs;
        logic [63:0] data;
    } mdl_t;

    typedef struct {
        bit          is_in;
        int          dly;
        logic [3:0]  pid;
        bit          vld;
        logic [63:0] pl;
        bit          exp_ok;
        bit          exp_ack;
        int          exp_rt;
        logic [63:0] exp_data;
    } vec_t;

    mdl_t ma = '0, mb = '0;
    int   n_cmp = 0, n_bad = 0;
    vec_t tv[9];

    function automatic mdl_t step(mdl_t m, int t, int r, bit st, bit ii, bit pav, bit vld,
                                  logic [98:0] p);
        mdl_t n;
        bit   good;
        n = m;
        good = vld && (m.dir ? p[87:84] == P_D0 : p[7:4] == P_ACK);
        n.ok = 0;
        n.err = 0;
        n.retry = 0;
        if (m.win) begin
            if (pav || m.age == t - 1) begin
                n.win = 0;
                n.ok = pav && good;
                n.retry = !n.ok;
                if (n.ok && m.dir) n.data = p[79:16];
            end else
                n.age = m.age + 1;
        end else if (m.retry) begin
            if (m.rs == r) n.err = 1;
            else begin
                n.rs = m.rs + 1;
                n.win = 1;
                n.age = 0;
            end
        end else if (!m.ok && !m.err && st) begin
            n.dir = ii;
            n.rs = 0;
            n.win = 1;
            n.age = 0;
        end
        return n;
    endfunction

    function automatic bit busy(mdl_t m);
        return m.win || m.retry || m.ok || m.err;
    endfunction

    function automatic logic [98:0] mk(logic [3:0] pid, logic [63:0] pl);
        logic [98:0] p = '0;
        p[87:84] = pid;
        p[79:16] = pl;
        p[15:8]  = 8'hA5;
        p[7:4]   = pid;
        p[3:0]   = ~pid;
        return p;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(string tag, mdl_t m, int r, logic de, logic rs, logic sa, logic td,
                       logic su, logic [63:0] d, logic [3:0] rt);
        chk({tag, ".decEn"},   de, m.win);
        chk({tag, ".resend"},  rs, m.retry && m.rs < r);
        chk({tag, ".sendAck"}, sa, m.ok && m.dir);
        chk({tag, ".txDone"},  td, m.ok || m.err);
        chk({tag, ".success"}, su, m.ok);
        chk({tag, ".dataOut"}, d,  m.data);
        chk({tag, ".retries"}, rt, 4'(m.rs));
    endtask

    task automatic cyc(bit r, bit st, bit ii, bit pav, bit vld, logic [98:0] p);
        rst = r;
        ia.start = st;
        ia.isIn = ii;
        ia.pktOutAvail = pav;
        ia.valid = vld;
        ia.pkt = p;
        @(posedge clk);
        ma = r ? '0 : step(ma, TA, RA, st, ii, pav, vld, p);
        mb = r ? '0 : step(mb, TB, RB, st, ii, pav, vld, p);
        @(negedge clk);
        cmp("A", ma, RA, ia.decEn, ia.resend, ia.sendAck, ia.txDone, ia.success, ia.dataOut, ia.retries);
        cmp("B", mb, RB, ib.decEn, ib.resend, ib.sendAck, ib.txDone, ib.success, ib.dataOut, ib.retries);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, '0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy(ma) || busy(mb)) begin
            if (k++ == 200) begin
                chk("idle_bound", 1, 0);
                break;
            end
            idle(1);
        end
    endtask

    task automatic run_vec(int i, vec_t v);
        int k = 0;
        cyc(0, 1, v.is_in, 0, 0, '0);
        idle(v.dly);
        cyc(0, 0, 0, 1, v.vld, mk(v.pid, v.pl));
        while (!ia.txDone && k < 100) begin
            idle(1);
            k++;
        end
        chk($sformatf("vec%0d.txDone", i), ia.txDone, 1);
        chk($sformatf("vec%0d.success", i), ia.success, v.exp_ok);
        chk($sformatf("vec%0d.sendAck", i), ia.sendAck, v.exp_ack);
        chk($sformatf("vec%0d.retries", i), ia.retries, 4'(v.exp_rt));
        chk($sformatf("vec%0d.dataOut", i), ia.dataOut, v.exp_data);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_de, n_rs, k, n_td;
        logic [98:0] p;

        tv[0] = '{0, 10, P_ACK, 1, 64'h0, 1, 0, 0, 64'h0};
        tv[1] = '{1, 3,  P_D0,  1, 64'hDEAD_BEEF_0123_4567, 1, 1, 0, 64'hDEAD_BEEF_0123_4567};
        tv[2] = '{1, 2,  P_D0,  0, 64'h1111_2222_3333_4444, 0, 0, 3, 64'hDEAD_BEEF_0123_4567};
        tv[3] = '{0, 15, P_ACK, 1, 64'h0, 1, 0, 0, 64'hDEAD_BEEF_0123_4567};
        tv[4] = '{0, 0,  P_NAK, 1, 64'h0, 0, 0, 3, 64'hDEAD_BEEF_0123_4567};
        tv[5] = '{1, 5,  P_ACK, 1, 64'h0, 0, 0, 3, 64'hDEAD_BEEF_0123_4567};
        tv[6] = '{0, 7,  P_ACK, 0, 64'h0, 0, 0, 3, 64'hDEAD_BEEF_0123_4567};
        tv[7] = '{1, 0,  P_D0,  1, 64'h0123_4567_89AB_CDEF, 1, 1, 0, 64'h0123_4567_89AB_CDEF};
        tv[8] = '{0, 4,  P_D0,  1, 64'h5555_AAAA_5555_AAAA, 0, 0, 3, 64'h0123_4567_89AB_CDEF};

        cyc(1, 0, 0, 0, 0, '0);
        chk("reset.decEn", ia.decEn, 0);
        chk("reset.txDone", ia.txDone, 0);
        chk("reset.dataOut", ia.dataOut, 0);
        cyc(0, 0, 0, 1, 1, mk(P_ACK, 0));
        chk("stray_pkt.txDone", ia.txDone, 0);

        foreach (tv[i]) run_vec(i, tv[i]);

        cyc(0, 1, 0, 0, 0, '0);
        idle(2);
        cyc(0, 0, 0, 1, 1, mk(P_NAK, 0));
        chk("nak.resend", ia.resend, 1);
        idle(1);
        chk("nak.retries", ia.retries, 1);
        chk("nak.decEn", ia.decEn, 1);
        idle(3);
        cyc(0, 0, 0, 1, 1, mk(P_ACK, 0));
        chk("nak_ack.success", ia.success, 1);
        chk("nak_ack.retries", ia.retries, 1);
        wait_idle();

        n_de = 0;
        n_rs = 0;
        k = 0;
        cyc(0, 1, 0, 0, 0, '0);
        while (!ib.txDone && k < 100) begin
            n_de += int'(ib.decEn);
            n_rs += int'(ib.resend);
            idle(1);
            k++;
        end
        chk("exhaust.decEn_cycles", n_de, 12);
        chk("exhaust.resends", n_rs, 2);
        chk("exhaust.txDone", ib.txDone, 1);
        chk("exhaust.success", ib.success, 0);
        chk("exhaust.retries", ib.retries, 2);
        wait_idle();

        cyc(0, 1, 1, 0, 0, '0);
        idle(3);
        cyc(1, 0, 0, 0, 0, '0);
        chk("midrst.decEn", ia.decEn, 0);
        chk("midrst.retries", ia.retries, 0);
        n_td = 0;
        for (int j = 0; j < 40; j++) begin
            idle(1);
            n_td += int'(ia.txDone) + int'(ib.txDone);
        end
        chk("midrst.no_txDone", n_td, 0);
        run_vec(100, '{0, 10, P_ACK, 1, 64'h0, 1, 0, 0, 64'h0});

        for (int j = 0; j < 3000; j++) begin
            logic [3:0] pid;
            p = 99'({$urandom(), $urandom(), $urandom(), $urandom()});
            case ($urandom_range(0, 3))
                0: pid = P_ACK;
                1: pid = P_NAK;
                2: pid = P_D0;
                default: pid = 4'($urandom());
            endcase
            p[87:84] = pid;
            p[7:4] = pid;
            cyc($urandom_range(0, 999) == 0, $urandom_range(0, 15) == 0, 1'($urandom()),
                $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
